clk_tick_rx: RTL and testbench

Receive end of the divided-clock scheme. Takes the toggling `fast_clk` and `blink_clk` signals produced by the clock divider and synchronizes them into the system `clk` domain. Emits one-cycle rising-edge strobes that downstream logic (snake step timer, display scan, blink overlay) uses as clock enables. Also checks each channel's period against the divider's configured ratio and flags lock loss or stuck clocks.

---
 rtl/snake_pkg.sv | 28 ++
 rtl/tick_chan.sv | 123 ++++++++++++
 rtl/clk_tick_rx.sv | 79 +++++++
 tb/tb_clk_tick_rx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// ============================================================================
// Module      : snake_pkg
// Description : Shared channel-state encoding and divider ratio defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snake_pkg;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } chan_state_t;

    // Divider and receiver both take their ratios from here.
    localparam int c_fast_half_dflt  = 100000;
    localparam int c_blink_half_dflt = 100000000;
    localparam int c_tol_dflt        = 16;

    function automatic int chan_limit(input int half, input int tol);
        return 2 * half + tol + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_chan.sv
// ============================================================================
// Module      : tick_chan
// Description : One divided-clock channel: synchronizer, rising-edge tick and,
//               when CLK_TICK_MON_EN is defined, a period-checking monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_chan
    import snake_pkg::*;
#(
    parameter int HALF = c_fast_half_dflt,
    parameter int TOL  = c_tol_dflt
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic tick,
    output logic locked,
    output logic fault_evt
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_tick  <= r_sync2 & ~r_prev;
        end
    end

    assign tick = r_tick;

`ifdef CLK_TICK_MON_EN
    localparam int c_limit = chan_limit(HALF, TOL);
    localparam int c_cnt_w = $clog2(c_limit + 1);
    localparam logic [c_cnt_w-1:0] c_limit_v = c_cnt_w'(c_limit);
    localparam logic [c_cnt_w-1:0] c_lo_v    = c_cnt_w'(2 * HALF - TOL);
    localparam logic [c_cnt_w-1:0] c_hi_v    = c_cnt_w'(2 * HALF + TOL);
    localparam logic [c_cnt_w-1:0] c_one_v   = c_cnt_w'(1);

    chan_state_t        r_state;
    chan_state_t        w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_locked;
    logic               w_good;

    assign w_good = (r_cnt >= c_lo_v) && (r_cnt <= c_hi_v);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= SEEK;
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_locked <= (w_state_nxt == LOCKED);
        end
    end

    // The tick itself is the edge event; the counter value seen alongside it
    // is the measured period.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            SEEK: begin
                w_cnt_nxt = '0;
                if (r_tick) begin
                    w_state_nxt = CHECK;
                    w_cnt_nxt   = c_one_v;
                end
            end
            CHECK, LOCKED: begin
                if (r_tick) begin
                    w_cnt_nxt   = c_one_v;
                    w_state_nxt = w_good ? LOCKED : FAULT;
                end else if (r_cnt == c_limit_v) begin
                    w_state_nxt = FAULT;
                end else begin
                    w_cnt_nxt = r_cnt + c_one_v;
                end
            end
            FAULT: begin
                if (r_tick) begin
                    w_state_nxt = CHECK;
                    w_cnt_nxt   = c_one_v;
                end else if (r_cnt != c_limit_v) begin
                    w_cnt_nxt = r_cnt + c_one_v;
                end
            end
            default: begin
                w_state_nxt = SEEK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign locked    = r_locked;
    assign fault_evt = (w_state_nxt == FAULT) && (r_state != FAULT);
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (HALF > 0) ^ (TOL > 0);
    assign locked       = 1'b1;
    assign fault_evt    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/clk_tick_rx.sv
// ============================================================================
// Module      : clk_tick_rx
// Description : Synchronizes fast_clk/blink_clk into clk, emits edge ticks and
//               (macro CLK_TICK_MON_EN) monitors their periods.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_tick_rx
    import snake_pkg::*;
#(
    parameter int FAST_HALF  = c_fast_half_dflt,
    parameter int BLINK_HALF = c_blink_half_dflt,
    parameter int TOL        = c_tol_dflt
) (
    input  logic clk,
    input  logic rst,
    input  logic fast_clk,
    input  logic blink_clk,
    input  logic fault_clr,
    output logic fast_tick,
    output logic blink_tick,
    output logic fast_locked,
    output logic blink_locked,
    output logic fault
);

    logic w_fast_evt;
    logic w_blink_evt;

    tick_chan #(
        .HALF (FAST_HALF),
        .TOL  (TOL)
    ) u_fast (
        .clk       (clk),
        .rst       (rst),
        .din       (fast_clk),
        .tick      (fast_tick),
        .locked    (fast_locked),
        .fault_evt (w_fast_evt)
    );

    tick_chan #(
        .HALF (BLINK_HALF),
        .TOL  (TOL)
    ) u_blink (
        .clk       (clk),
        .rst       (rst),
        .din       (blink_clk),
        .tick      (blink_tick),
        .locked    (blink_locked),
        .fault_evt (w_blink_evt)
    );

`ifdef CLK_TICK_MON_EN
    logic r_fault;

    // A new fault event takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_fast_evt || w_blink_evt) begin
            r_fault <= 1'b1;
        end else if (fault_clr) begin
            r_fault <= 1'b0;
        end
    end

    assign fault = r_fault;
`else
    logic w_unused_bits;

    assign w_unused_bits = ^{fault_clr, w_fast_evt, w_blink_evt};
    assign fault         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_tick_rx.sv
// ============================================================================
// Module      : tb_clk_tick_rx
// Description : Directed bench for clk_tick_rx (FAST_HALF=4, BLINK_HALF=10,
//               TOL=1); follows CLK_TICK_MON_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_tick_rx;

`ifdef CLK_TICK_MON_EN
    localparam bit c_mon = 1'b1;
`else
    localparam bit c_mon = 1'b0;
`endif

    logic clk;
    logic rst;
    logic fast_clk;
    logic blink_clk;
    logic fault_clr;
    logic fast_tick;
    logic blink_tick;
    logic fast_locked;
    logic blink_locked;
    logic fault;

    int checks = 0;
    int errors = 0;

    clk_tick_rx #(
        .FAST_HALF  (4),
        .BLINK_HALF (10),
        .TOL        (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fast_clk     (fast_clk),
        .blink_clk    (blink_clk),
        .fault_clr    (fault_clr),
        .fast_tick    (fast_tick),
        .blink_tick   (blink_tick),
        .fast_locked  (fast_locked),
        .blink_locked (blink_locked),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic pat(input int k, input int hi, input int lo);
        return (k % (hi + lo)) < hi;
    endfunction

    // Apply one cycle of inputs and return just after the edge that samples them.
    task automatic step(input logic f, input logic b, input logic c, input logic r);
        fast_clk  = f;
        blink_clk = b;
        fault_clr = c;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        exp = c_mon ? 5'b00000 : 5'b00110;
        checks++;
        if ({fast_tick, blink_tick, fast_locked, blink_locked, fault} !== exp) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {fast_tick, blink_tick, fast_locked, blink_locked, fault}, exp);
        end
    endtask

    task automatic test_fast_lock();
        logic e_tick, e_lock;
        test_reset();
        for (int k = 0; k < 30; k++) begin
            step(pat(k, 4, 4), 1'b0, 1'b0, 1'b0);
            e_tick = (k % 8 == 2);
            e_lock = c_mon ? (k >= 11) : 1'b1;
            checks++;
            if (fast_tick !== e_tick) begin
                errors++;
                $display("FAIL fast_lock_tick k=%0d got=%b exp=%b", k, fast_tick, e_tick);
            end
            checks++;
            if (fast_locked !== e_lock) begin
                errors++;
                $display("FAIL fast_lock_locked k=%0d got=%b exp=%b", k, fast_locked, e_lock);
            end
            checks++;
            if (fault !== 1'b0) begin
                errors++;
                $display("FAIL fast_lock_fault k=%0d got=%b exp=0", k, fault);
            end
        end
    endtask

`ifdef CLK_TICK_MON_EN
    // Periods 7 and 9 sit on the accepted window edges, 6 and 10 just outside.
    task automatic test_period_window();
        int hi_t [4] = '{4, 5, 3, 5};
        int lo_t [4] = '{3, 4, 3, 5};
        bit good [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int p;
        logic e_tick, e_lock, e_fault;
        for (int t = 0; t < 4; t++) begin
            test_reset();
            p = hi_t[t] + lo_t[t];
            for (int k = 0; k < p + 5; k++) begin
                step(pat(k, hi_t[t], lo_t[t]), 1'b0, 1'b0, 1'b0);
                e_tick  = (k == 2) || (k == p + 2);
                e_lock  = good[t] && (k >= p + 3);
                e_fault = !good[t] && (k >= p + 3);
                checks++;
                if (fast_tick !== e_tick) begin
                    errors++;
                    $display("FAIL window_tick P=%0d k=%0d got=%b exp=%b", p, k, fast_tick, e_tick);
                end
                checks++;
                if (fast_locked !== e_lock) begin
                    errors++;
                    $display("FAIL window_locked P=%0d k=%0d got=%b exp=%b", p, k, fast_locked, e_lock);
                end
                checks++;
                if (fault !== e_fault) begin
                    errors++;
                    $display("FAIL window_fault P=%0d k=%0d got=%b exp=%b", p, k, fault, e_fault);
                end
            end
        end
    endtask

    // Lock blink at period 20 then stop it: last tick k=22, counter hits 22 after k=44.
    task automatic test_blink_timeout();
        logic e_tick, e_lock, e_fault;
        test_reset();
        for (int k = 0; k < 50; k++) begin
            step(1'b0, (k < 40) ? pat(k, 10, 10) : 1'b0, 1'b0, 1'b0);
            e_tick  = (k == 2) || (k == 22);
            e_lock  = (k >= 23) && (k < 45);
            e_fault = (k >= 45);
            checks++;
            if (blink_tick !== e_tick) begin
                errors++;
                $display("FAIL timeout_tick k=%0d got=%b exp=%b", k, blink_tick, e_tick);
            end
            checks++;
            if (blink_locked !== e_lock) begin
                errors++;
                $display("FAIL timeout_locked k=%0d got=%b exp=%b", k, blink_locked, e_lock);
            end
            checks++;
            if (fault !== e_fault) begin
                errors++;
                $display("FAIL timeout_fault k=%0d got=%b exp=%b", k, fault, e_fault);
            end
        end
    endtask

    // Continues from the blink timeout with fault set.
    task automatic test_fault_clr();
        logic e_fault;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL clr_alone got=%b exp=0", fault);
        end
        // Fast period 10 raises its fault event in the tick cycle before edge 13.
        for (int k = 0; k < 17; k++) begin
            step(pat(k, 5, 5), 1'b0, (k == 13) || (k == 15), 1'b0);
            e_fault = (k == 13) || (k == 14);
            checks++;
            if (fault !== e_fault) begin
                errors++;
                $display("FAIL clr_vs_set k=%0d got=%b exp=%b", k, fault, e_fault);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic e_ft, e_bt, e_fl, e_bl;
        test_reset();
        for (int k = 0; k < 46; k++) begin
            step(pat(k, 4, 4), pat(k, 10, 10), 1'b0, (k == 30));
            e_ft = (k < 30) ? (k % 8 == 2) : ((k == 34) || (k == 42));
            e_bt = (k < 30) ? ((k == 2) || (k == 22)) : (k == 42);
            e_fl = ((k >= 11) && (k < 30)) || (k >= 43);
            e_bl = (k >= 23) && (k < 30);
            checks++;
            if ({fast_tick, blink_tick, fast_locked, blink_locked, fault} !==
                {e_ft, e_bt, e_fl, e_bl, 1'b0}) begin
                errors++;
                $display("FAIL reset_mid k=%0d got=%b exp=%b", k,
                         {fast_tick, blink_tick, fast_locked, blink_locked, fault},
                         {e_ft, e_bt, e_fl, e_bl, 1'b0});
            end
        end
    endtask
`else
    task automatic test_no_monitor();
        logic e_tick;
        test_reset();
        for (int k = 0; k < 32; k++) begin
            step(pat(k, 5, 5), 1'b0, k[0], 1'b0);
            e_tick = (k % 10 == 2);
            checks++;
            if (fast_tick !== e_tick) begin
                errors++;
                $display("FAIL nomon_tick k=%0d got=%b exp=%b", k, fast_tick, e_tick);
            end
            checks++;
            if ({fast_locked, blink_locked, fault} !== 3'b110) begin
                errors++;
                $display("FAIL nomon_status k=%0d got=%b exp=110", k,
                         {fast_locked, blink_locked, fault});
            end
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        fast_clk  = 1'b0;
        blink_clk = 1'b0;
        fault_clr = 1'b0;
        test_reset();
        test_fast_lock();
`ifdef CLK_TICK_MON_EN
        test_period_window();
        test_blink_timeout();
        test_fault_clr();
        test_reset_mid();
`else
        test_no_monitor();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
